joy_neogeo_mapper: RTL



---
 rtl/joy_neogeo_mapper.sv | 111 +++++++++++
 1 files changed

// File: rtl/joy_neogeo_mapper.sv
// joy_neogeo_mapper: debounced Mega Drive -> NeoGeo joystick mapper with SOCD cleaning and a Start+Mode OSD hotkey.
// Autofire is built only when JOY_AUTOFIRE_EN is defined; otherwise af_en/af_mask are ignored.
module joy_neogeo_mapper #(
  parameter int TICK_DIV    = 49999,
  parameter int AF_HALF     = 33,
  parameter int COMBO_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] joy1_i,
  input  logic [11:0] joy2_i,
  input  logic [1:0]  af_en,
  input  logic [3:0]  af_mask,
  output logic [9:0]  neo1_o,
  output logic [9:0]  neo2_o,
  output logic        osd_toggle
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FIRED} state_t;
  logic [15:0]     r_tick_cnt;
  logic            w_tick;
  logic [23:0]     w_raw, w_agree, w_deb_nxt, r_h0, r_h1, r_deb;
  logic [1:0][3:0] w_gate;
  logic [1:0][9:0] w_map;
  state_t          r_state, w_state_nxt;
  logic [10:0]     r_combo_cnt;
  logic            w_held, w_combo_done, w_fire, w_force;
  logic            w_unused_yz;

  assign w_tick = r_tick_cnt == 16'(TICK_DIV);
  always_ff @(posedge clk)
    r_tick_cnt <= (reset || w_tick) ? '0 : r_tick_cnt + 16'd1;

  // a bit only moves when the current sample and both older samples agree
  assign w_raw     = {joy2_i, joy1_i};
  assign w_agree   = ~(w_raw ^ r_h0) & ~(w_raw ^ r_h1);
  assign w_deb_nxt = w_tick ? (r_deb & ~w_agree) | (w_raw & w_agree) : r_deb;
  always_ff @(posedge clk)
    if (reset) begin
      r_h0  <= '1;
      r_h1  <= '1;
      r_deb <= '1;
    end else begin
      r_deb <= w_deb_nxt;
      if (w_tick) begin
        r_h1 <= r_h0;
        r_h0 <= w_raw;
      end
    end

`ifdef JOY_AUTOFIRE_EN
  logic [7:0] r_af_cnt;
  logic       r_phase, w_af_wrap;
  assign w_af_wrap = r_af_cnt == 8'(AF_HALF - 1);
  always_ff @(posedge clk)
    if (reset) begin
      r_af_cnt <= '0;
      r_phase  <= 1'b0;
    end else if (w_tick) begin
      r_af_cnt <= w_af_wrap ? '0 : r_af_cnt + 8'd1;
      r_phase  <= r_phase ^ w_af_wrap;
    end
  assign w_gate[0] = {4{af_en[0] & r_phase}} & af_mask;
  assign w_gate[1] = {4{af_en[1] & r_phase}} & af_mask;
`else
  logic w_unused_af;
  assign w_unused_af = ^{af_en, af_mask};
  assign w_gate      = '0;
`endif

  // hotkey reacts to the debounced value being written this edge so a release beats a completing tick
  assign w_held       = ~w_deb_nxt[7] & ~w_deb_nxt[11];
  assign w_combo_done = r_combo_cnt + 11'd1 == 11'(COMBO_TICKS);
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_state_nxt;
  always_comb
    w_state_nxt = !w_held ? S_IDLE :
                  r_state == S_IDLE ? S_HOLD :
                  (r_state == S_HOLD && w_tick && w_combo_done) ? S_FIRED : r_state;
  always_comb begin
    w_fire  = r_state == S_HOLD && w_state_nxt == S_FIRED;
    w_force = r_state != S_IDLE;
  end
  always_ff @(posedge clk)
    if (reset || w_state_nxt != S_HOLD) r_combo_cnt <= '0;
    else if (r_state == S_HOLD && w_tick) r_combo_cnt <= r_combo_cnt + 11'd1;

  for (genvar p = 0; p < 2; p++) begin : g_map
    localparam int O = 12 * p;
    logic w_ud, w_lr, w_ss;
    assign w_ud     = ~(r_deb[O] | r_deb[O+1]);
    assign w_lr     = ~(r_deb[O+2] | r_deb[O+3]);
    assign w_ss     = (p == 0) & w_force;
    assign w_map[p] = {r_deb[O+11] | w_ss, r_deb[O+7] | w_ss,
                       r_deb[O+10] | w_gate[p][3], r_deb[O+5] | w_gate[p][2],
                       r_deb[O+4] | w_gate[p][1], r_deb[O+6] | w_gate[p][0],
                       r_deb[O+3] | w_lr, r_deb[O+2] | w_lr,
                       r_deb[O+1] | w_ud, r_deb[O] | w_ud};
  end
  assign w_unused_yz = ^{r_deb[9:8], r_deb[21:20]};

  always_ff @(posedge clk)
    if (reset) begin
      neo1_o     <= '1;
      neo2_o     <= '1;
      osd_toggle <= 1'b0;
    end else begin
      neo1_o     <= w_map[0];
      neo2_o     <= w_map[1];
      osd_toggle <= w_fire;
    end
endmodule
